// File: rtl/hcs_alert_tx.sv
// hcs_alert_tx: serial alert transmitter for the bedside monitor link.
// Snapshots the four abnormality flags and the glycemic index into an 8-bit
// payload and sends it as an 11-bit frame (start, D0..D7, even parity, stop).
// A frame goes out on request, or whenever the flag field differs from the
// flags carried by the last frame sent.
module hcs_alert_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       presureAbnormality,
    input  logic       bloodAbnormality,
    input  logic       fallDetected,
    input  logic       temperatureAbnormality,
    input  logic [3:0] glycemicIndex,
    input  logic       send_req,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [7:0] frame_cnt
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]        state;
    logic [BAUD_W-1:0] baudCnt;
    logic [2:0]        bitCnt;
    logic [7:0]        shiftReg;
    logic              parityBit;
    logic [3:0]        lastFlags;
    logic              pending;

    logic [3:0]        flagsNow;
    logic [7:0]        payloadNow;
    logic              trigger;
    logic              bitEnd;

    logic              txReg;
    logic              busyReg;
    logic              doneReg;
    logic [7:0]        frameCnt;

    // Payload assembly, frame trigger and end-of-bit decode.
    always_comb begin
        flagsNow   = {presureAbnormality, bloodAbnormality, fallDetected, temperatureAbnormality};
        payloadNow = {flagsNow, glycemicIndex};
        trigger    = (state == IDLE) && (send_req || pending || (flagsNow != lastFlags));
        bitEnd     = (baudCnt == BAUD_LAST);
    end

    // Frame sequencing: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (trigger) state <= START;
                START:   if (bitEnd) state <= DATA;
                DATA:    if (bitEnd && (bitCnt == 3'd7)) state <= PARITY;
                PARITY:  if (bitEnd) state <= STOP;
                STOP:    if (bitEnd) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Baud counter restarts on every bit; data-bit index advances per data bit.
    always_ff @(posedge clk) begin
        if (!rst_n || (state == IDLE)) begin
            baudCnt <= '0;
            bitCnt  <= '0;
        end else begin
            baudCnt <= bitEnd ? '0 : baudCnt + 1'b1;
            if ((state == DATA) && bitEnd) begin
                bitCnt <= bitCnt + 3'd1;
            end
        end
    end

    // Payload capture, shifting, last-sent flags and the one-deep request latch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shiftReg  <= '0;
            parityBit <= 1'b0;
            lastFlags <= '0;
            pending   <= 1'b0;
        end else if (trigger) begin
            shiftReg  <= payloadNow;
            parityBit <= ^payloadNow;
            lastFlags <= flagsNow;
            pending   <= 1'b0;
        end else begin
            if ((state != IDLE) && send_req) begin
                pending <= 1'b1;
            end
            if ((state == DATA) && bitEnd) begin
                shiftReg <= shiftReg >> 1;
            end
        end
    end

    // Registered line, busy/done flags and completed-frame counter.
    // tx is loaded one bit ahead, so during DATA the next bit is shiftReg[1].
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            txReg    <= 1'b1;
            busyReg  <= 1'b0;
            doneReg  <= 1'b0;
            frameCnt <= '0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        txReg   <= 1'b0;
                        busyReg <= 1'b1;
                    end
                end
                START: begin
                    if (bitEnd) txReg <= shiftReg[0];
                end
                DATA: begin
                    if (bitEnd) txReg <= (bitCnt == 3'd7) ? parityBit : shiftReg[1];
                end
                PARITY: begin
                    if (bitEnd) txReg <= 1'b1;
                end
                STOP: begin
                    if (bitEnd) begin
                        txReg    <= 1'b1;
                        busyReg  <= 1'b0;
                        doneReg  <= 1'b1;
                        frameCnt <= frameCnt + 8'd1;
                    end
                end
                default: begin
                    txReg   <= 1'b1;
                    busyReg <= 1'b0;
                end
            endcase
        end
    end

    assign tx        = txReg;
    assign busy      = busyReg;
    assign done      = doneReg;
    assign frame_cnt = frameCnt;

endmodule

// File: tb/tb_hcs_alert_tx.sv
// tb_hcs_alert_tx: directed bench for hcs_alert_tx with CLKS_PER_BIT=4.
// Expected payloads are queued when stimulus is driven; a line monitor
// decodes each frame from tx and compares it against the queue head.
module tb_hcs_alert_tx;

    localparam int CPB = 4;

    logic       clk;
    logic       rst_n;
    logic       presureAbnormality;
    logic       bloodAbnormality;
    logic       fallDetected;
    logic       temperatureAbnormality;
    logic [3:0] glycemicIndex;
    logic       send_req;
    logic       tx;
    logic       busy;
    logic       done;
    logic [7:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int abortCount = 0;
    logic [7:0] expQ[$];

    hcs_alert_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .presureAbnormality     (presureAbnormality),
        .bloodAbnormality       (bloodAbnormality),
        .fallDetected           (fallDetected),
        .temperatureAbnormality (temperatureAbnormality),
        .glycemicIndex          (glycemicIndex),
        .send_req               (send_req),
        .tx                     (tx),
        .busy                   (busy),
        .done                   (done),
        .frame_cnt              (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Line monitor: decode one frame per busy period and score it.
    initial begin : monitor
        logic [10:0] obs;
        logic [10:0] expFrame;
        logic [7:0]  p;
        bit          aborted;
        bit          unstable;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                obs = '0;
                aborted = 0;
                unstable = 0;
                for (int n = 0; n < 11 * CPB; n++) begin
                    if (n != 0) @(negedge clk);
                    if (busy !== 1'b1) begin
                        aborted = 1;
                        break;
                    end
                    if (n % CPB == 0) obs[n / CPB] = tx;
                    else if (tx !== obs[n / CPB]) unstable = 1;
                end
                if (aborted) begin
                    abortCount++;
                    if (expQ.size() > 0) void'(expQ.pop_front());
                end else begin
                    @(negedge clk);
                    checks++;
                    assert (done === 1'b1 && busy === 1'b0) else begin
                        errors++;
                        $error("FAIL frame_end: done=%b busy=%b required done=1 busy=0", done, busy);
                    end
                    checks++;
                    assert (unstable === 1'b0) else begin
                        errors++;
                        $error("FAIL bit_hold: tx changed inside a bit, frame=%b", obs);
                    end
                    checks++;
                    assert (expQ.size() > 0) else begin
                        errors++;
                        $error("FAIL unexpected_frame: got frame %b with nothing expected", obs);
                    end
                    if (expQ.size() > 0) begin
                        p = expQ.pop_front();
                        expFrame = {1'b1, ^p, p, 1'b0};
                        checks++;
                        assert (obs === expFrame) else begin
                            errors++;
                            $error("FAIL frame_bits: got %b required %b", obs, expFrame);
                        end
                    end
                end
            end
        end
    end

    task automatic waitDone(input string tag, input int budget);
        bit found;
        found = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                found = 1;
                break;
            end
        end
        checks++;
        assert (found) else begin
            errors++;
            $error("FAIL timeout_%s: done=%b required a done pulse within %0d cycles", tag, done, budget);
        end
    endtask

    task automatic idleCheck(input string tag, input int n);
        int busyCycles;
        int doneCycles;
        busyCycles = 0;
        doneCycles = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) busyCycles++;
            if (done !== 1'b0) doneCycles++;
        end
        checks++;
        assert (busyCycles == 0 && doneCycles == 0) else begin
            errors++;
            $error("FAIL idle_%s: busy cycles=%0d done cycles=%0d required 0 and 0", tag, busyCycles, doneCycles);
        end
    endtask

    task automatic checkCnt(input string tag, input logic [7:0] want);
        checks++;
        assert (frame_cnt === want) else begin
            errors++;
            $error("FAIL cnt_%s: frame_cnt=%0d required %0d", tag, frame_cnt, want);
        end
    endtask

    task automatic pulseReq();
        send_req = 1'b1;
        @(negedge clk);
        send_req = 1'b0;
    endtask

    initial begin : stimulus
        rst_n = 1'b0;
        presureAbnormality = 1'b0;
        bloodAbnormality = 1'b0;
        fallDetected = 1'b0;
        temperatureAbnormality = 1'b0;
        glycemicIndex = 4'd0;
        send_req = 1'b0;

        // 1: reset and quiet line
        repeat (3) @(negedge clk);
        checks++;
        assert (tx === 1'b1 && busy === 1'b0 && done === 1'b0 && frame_cnt === 8'd0) else begin
            errors++;
            $error("FAIL reset_state: tx=%b busy=%b done=%b cnt=%0d required 1 0 0 0", tx, busy, done, frame_cnt);
        end
        rst_n = 1'b1;
        idleCheck("quiet", 100);
        checks++;
        assert (tx === 1'b1) else begin
            errors++;
            $error("FAIL quiet_tx: tx=%b required 1", tx);
        end
        checkCnt("quiet", 8'd0);

        // 2: request together with a flag change gives exactly one frame
        presureAbnormality = 1'b1;
        fallDetected = 1'b1;
        glycemicIndex = 4'd5;
        expQ.push_back(8'hA5);
        pulseReq();
        checks++;
        assert (busy === 1'b1 && tx === 1'b0) else begin
            errors++;
            $error("FAIL start_latency: busy=%b tx=%b required 1 0", busy, tx);
        end
        waitDone("a5", 100);
        checkCnt("a5", 8'd1);
        @(negedge clk);
        checks++;
        assert (done === 1'b0) else begin
            errors++;
            $error("FAIL done_width: done=%b required 0", done);
        end
        idleCheck("after_a5", 30);

        // 3: flag-only change sends 0x20; glycemic change mid-frame and afterwards is ignored
        presureAbnormality = 1'b0;
        glycemicIndex = 4'd0;
        expQ.push_back(8'h20);
        repeat (10) @(negedge clk);
        glycemicIndex = 4'd9;
        waitDone("auto20", 100);
        checkCnt("auto20", 8'd2);
        idleCheck("hold_flag", 100);

        // 4: mid-DATA request queues one frame; extra requests merge
        expQ.push_back(8'h29);
        pulseReq();
        repeat (12) @(negedge clk);
        expQ.push_back(8'h29);
        pulseReq();
        waitDone("first29", 100);
        checkCnt("first29", 8'd3);
        @(negedge clk);
        checks++;
        assert (busy === 1'b1 && tx === 1'b0) else begin
            errors++;
            $error("FAIL gap_one: busy=%b tx=%b required 1 0", busy, tx);
        end
        repeat (10) @(negedge clk);
        expQ.push_back(8'h29);
        pulseReq();
        repeat (10) @(negedge clk);
        pulseReq();
        waitDone("second29", 100);
        checkCnt("second29", 8'd4);
        waitDone("merged29", 100);
        checkCnt("merged29", 8'd5);
        idleCheck("after_merge", 60);

        // 5: reset during the third data bit aborts the frame
        expQ.push_back(8'h29);
        pulseReq();
        repeat (12) @(negedge clk);
        fallDetected = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        assert (tx === 1'b1 && busy === 1'b0 && done === 1'b0 && frame_cnt === 8'd0) else begin
            errors++;
            $error("FAIL abort_state: tx=%b busy=%b done=%b cnt=%0d required 1 0 0 0", tx, busy, done, frame_cnt);
        end
        idleCheck("after_abort", 20);
        checks++;
        assert (abortCount == 1) else begin
            errors++;
            $error("FAIL abort_seen: aborted frames=%0d required 1", abortCount);
        end
        expQ.push_back(8'h09);
        pulseReq();
        waitDone("fresh", 100);
        checkCnt("fresh", 8'd1);

        // 6: 256 back-to-back requests, counter wraps
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        glycemicIndex = 4'd0;
        expQ.push_back(8'h00);
        pulseReq();
        for (int i = 1; i <= 256; i++) begin
            waitDone("b2b", 100);
            if (i == 255) checkCnt("b2b_255", 8'd255);
            if (i == 256) checkCnt("b2b_256", 8'd0);
            if (i < 256) begin
                glycemicIndex = 4'(i % 16);
                expQ.push_back({4'b0000, 4'(i % 16)});
                pulseReq();
            end
        end
        idleCheck("end", 20);
        checks++;
        assert (expQ.size() == 0) else begin
            errors++;
            $error("FAIL queue_drained: %0d frames never seen, required 0", expQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hcs_alert_tx.md
# hcs_alert_tx

Serial alert transmitter on the output side of the health-care system. It snapshots the four abnormality flags and the 4-bit glycemic index into an 8-bit payload. It sends the payload as an 11-bit UART-style frame to the bedside monitor link. A frame is sent on explicit request, or automatically whenever any abnormality flag differs from the value in the last frame sent.

## Interface

Parameters:
- CLKS_PER_BIT, default 16: clock cycles per serial bit; legal values are 2 or more.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- presureAbnormality, input, 1: pressure flag.
- bloodAbnormality, input, 1: blood flag.
- fallDetected, input, 1: fall flag.
- temperatureAbnormality, input, 1: temperature flag.
- glycemicIndex, input, 4: glycemic index.
- send_req, input, 1: request one frame; level is sampled every cycle.
- tx, output, 1: serial line; idles high.
- busy, output, 1: high while a frame is on the line (start through stop).
- done, output, 1: one-cycle pulse after the stop bit completes.
- frame_cnt, output, 8: count of completed frames; wraps.

## Operation

Payload bit layout:
- [7] presureAbnormality
- [6] bloodAbnormality
- [5] fallDetected
- [4] temperatureAbnormality
- [3:0] glycemicIndex

Frame format: start bit (0), payload bits D0..D7 LSB first, even-parity bit (XOR of D7..D0), stop bit (1).

State machine: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
- IDLE: tx=1. A trigger is any of:
  - send_req=1
  - pending=1
  - the flag field {payload[7:4]} differs from last_flags
- On a trigger:
  - capture the payload into the shift register
  - load last_flags with the captured flags
  - clear pending
  - go to START
- START, DATA, PARITY, STOP: each bit is held for exactly CLKS_PER_BIT cycles.
  - A baud counter runs 0..CLKS_PER_BIT-1 and restarts on each bit.
  - DATA uses a 3-bit counter, 0..7, and leaves after D7.
- STOP: after its final cycle, go to IDLE. In that first IDLE cycle:
  - done=1
  - frame_cnt increments (255 wraps to 0)
- Input changes during a frame have no effect on the frame in flight.
- send_req=1 while busy sets pending (one deep). Further requests while pending is set are merged.
- Flag changes during a frame are not queued. They are caught by the last_flags comparison once back in IDLE.
- send_req and a flag change in the same IDLE cycle produce exactly one frame.
- glycemicIndex changes alone never trigger a frame.

Reset (rst_n=0 at an edge):
- tx=1, busy=0, done=0, frame_cnt=0
- state IDLE, last_flags=0, pending=0, counters 0

Reset mid-frame aborts the frame:
- tx is high after that edge
- no done pulse
- frame_cnt unchanged from its reset value 0

## Timing

- A trigger sampled in IDLE at edge k gives tx=0 and busy=1 from edge k+1.
- Frame duration is 11*CLKS_PER_BIT cycles with busy=1. done and busy=0 follow in the next cycle.
- Back-to-back frames: the earliest next trigger is the done cycle. The minimum tx-high gap between frames is 1 cycle beyond the stop bit.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

All scenarios use CLKS_PER_BIT=4.

1. Reset, then hold all inputs at 0 for 100 cycles -> tx=1, busy=0, done never asserted, frame_cnt=0.
2. Flags 1,0,1,0 with glycemicIndex=5 (payload 0xA5), pulse send_req -> starting one cycle later, tx bits are 0, 1,0,1,0,0,1,0,1, parity 0, stop 1, each bit held 4 cycles. busy is high for 44 cycles, then done pulses once and frame_cnt=1.
3. Raise fallDetected only, no send_req (payload 0x20) -> auto frame with data bits 0,0,0,0,0,1,0,0 and parity 1. Holding fallDetected high afterwards sends no further frames.
4. Pulse send_req in mid-DATA of a frame -> a second frame starts on the cycle after done, with exactly a 1-cycle tx-high gap after the stop bit. Two extra pulses during the same frame still give only one extra frame.
5. Drive rst_n=0 for one edge during the third data bit -> tx=1 and busy=0 after that edge, no done pulse, frame_cnt=0. A fresh send_req then produces a complete, correct frame.
6. Issue 256 back-to-back send_req frames -> frame_cnt reads 255 after the 255th done and 0 after the 256th.
